// File: rtl/nand_deser8.sv
// 8-bit MSB-first serial-to-parallel deserializer mapped onto NAND/NOT logic
// feeding plain positive-edge flops; reset is folded into every D input.
module nand_deser8 (
   input  logic       C,
   input  logic       R,
   input  logic       SYNC,
   input  logic       S_VALID,
   input  logic       S_IN,
   output logic [7:0] P_OUT,
   output logic       P_VALID,
   output logic       BUSY
);

   function automatic logic nand2(input logic a, input logic b);
      return ~(a & b);
   endfunction

   function automatic logic nand3(input logic a, input logic b, input logic c);
      return ~(a & b & c);
   endfunction

   function automatic logic inv(input logic a);
      return nand2(a, a);
   endfunction

   function automatic logic and2(input logic a, input logic b);
      return inv(nand2(a, b));
   endfunction

   function automatic logic or2(input logic a, input logic b);
      return nand2(inv(a), inv(b));
   endfunction

   function automatic logic or3(input logic a, input logic b, input logic c);
      return nand3(inv(a), inv(b), inv(c));
   endfunction

   function automatic logic xor2(input logic a, input logic b);
      logic n;
      n = nand2(a, b);
      return nand2(nand2(a, n), nand2(b, n));
   endfunction

   function automatic logic mux2(input logic s, input logic a1, input logic a0);
      return nand2(nand2(s, a1), nand2(inv(s), a0));
   endfunction

   logic [6:0] sr, sr_d;
   logic [2:0] cnt, cnt_d, cnt_inc;
   logic [7:0] pout_d, byte_full;
   logic       pvalid_d;
   logic       r_n, sync_n, adv, restart, hold, is7, complete, shift, load0;

   always_comb begin
      r_n      = inv(R);
      sync_n   = inv(SYNC);
      adv      = and2(S_VALID, sync_n);
      restart  = and2(SYNC, S_VALID);
      hold     = and2(sync_n, inv(S_VALID));
      is7      = inv(nand3(cnt[0], cnt[1], cnt[2]));
      complete = and2(adv, is7);
      shift    = and2(adv, inv(is7));
      load0    = or2(shift, restart);

      // Ripple incrementer; 7 rolls to 0, which is only selected on completion.
      cnt_inc[0] = inv(cnt[0]);
      cnt_inc[1] = xor2(cnt[1], cnt[0]);
      cnt_inc[2] = xor2(cnt[2], and2(cnt[1], cnt[0]));

      byte_full = {sr, S_IN};
      sr_d      = '0;
      cnt_d     = '0;
      pout_d    = '0;

      // Any case not selected (completion, bare SYNC, reset) clears SR and CNT.
      sr_d[0] = and2(r_n, or2(and2(load0, S_IN), and2(hold, sr[0])));
      for (int unsigned i = 1; i < 7; i++)
         sr_d[i] = and2(r_n, or2(and2(shift, sr[i-1]), and2(hold, sr[i])));

      cnt_d[0] = and2(r_n, or3(and2(adv, cnt_inc[0]), and2(hold, cnt[0]), restart));
      for (int unsigned i = 1; i < 3; i++)
         cnt_d[i] = and2(r_n, or2(and2(adv, cnt_inc[i]), and2(hold, cnt[i])));

      for (int unsigned i = 0; i < 8; i++)
         pout_d[i] = and2(r_n, mux2(complete, byte_full[i], P_OUT[i]));

      pvalid_d = and2(r_n, complete);
   end

   always_ff @(posedge C) begin
      sr      <= sr_d;
      cnt     <= cnt_d;
      P_OUT   <= pout_d;
      P_VALID <= pvalid_d;
   end

   assign BUSY = or3(cnt[0], cnt[1], cnt[2]);

endmodule
